// File: rtl/alu_share_arbiter_if.sv
// Request/response channel between two ALU requesters and the shared-ALU arbiter.
// The master side is the requester/consumer; the slave side is the arbiter.
interface alu_share_arbiter_if;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_instr0;
   logic [31:0] req_instr1;
   logic [31:0] req_a0;
   logic [31:0] req_a1;
   logic [31:0] req_b0;
   logic [31:0] req_b1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic [2:0]  rsp_flags;

   modport master (
      output req_valid, req_instr0, req_instr1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
   );

   modport slave (
      input  req_valid, req_instr0, req_instr1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Combinational MIPS-subset ALU plus a round-robin arbiter/sequencer sharing it between
// two requesters. ALU flags = {zero, negative, signed overflow (add/sub/addi only)}.
module alu (
   input  logic [31:0] instruction,
   input  logic [31:0] reg_a,
   input  logic [31:0] reg_b,
   output logic [31:0] result,
   output logic [2:0]  flags
);
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] imm_s;
   logic [31:0] imm_z;
   logic        ovf;

   assign opcode = instruction[31:26];
   assign funct  = instruction[5:0];
   assign shamt  = instruction[10:6];
   assign imm_s  = {{16{instruction[15]}}, instruction[15:0]};
   assign imm_z  = {16'h0000, instruction[15:0]};

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      if (opcode == 6'h00) begin
         case (funct)
            6'h00: result = reg_b << shamt;
            6'h02: result = reg_b >> shamt;
            6'h03: result = $signed(reg_b) >>> shamt;
            6'h20: begin
               result = reg_a + reg_b;
               ovf    = (reg_a[31] == reg_b[31]) && (result[31] != reg_a[31]);
            end
            6'h21: result = reg_a + reg_b;
            6'h22: begin
               result = reg_a - reg_b;
               ovf    = (reg_a[31] != reg_b[31]) && (result[31] != reg_a[31]);
            end
            6'h23: result = reg_a - reg_b;
            6'h24: result = reg_a & reg_b;
            6'h25: result = reg_a | reg_b;
            6'h26: result = reg_a ^ reg_b;
            6'h27: result = ~(reg_a | reg_b);
            6'h2a: result = {31'b0, $signed(reg_a) < $signed(reg_b)};
            6'h2b: result = {31'b0, reg_a < reg_b};
            default: result = '0;
         endcase
      end else begin
         case (opcode)
            6'h08: begin
               result = reg_a + imm_s;
               ovf    = (reg_a[31] == imm_s[31]) && (result[31] != reg_a[31]);
            end
            6'h09: result = reg_a + imm_s;
            6'h0a: result = {31'b0, $signed(reg_a) < $signed(imm_s)};
            6'h0b: result = {31'b0, reg_a < imm_s};
            6'h0c: result = reg_a & imm_z;
            6'h0d: result = reg_a | imm_z;
            6'h0e: result = reg_a ^ imm_z;
            6'h0f: result = {instruction[15:0], 16'h0000};
            default: result = '0;
         endcase
      end
   end

   assign flags = {result == 32'h0, result[31], ovf};
endmodule

module alu_share_arbiter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave bus,
   output logic               busy,
   output logic [CNT_W-1:0]   grant_cnt0,
   output logic [CNT_W-1:0]   grant_cnt1
);
   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e           state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             cur_id_q, cur_id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      op_instr_q, op_instr_d;
   logic [31:0]      op_a_q, op_a_d;
   logic [31:0]      op_b_q, op_b_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic [2:0]       rsp_flags_q, rsp_flags_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic [31:0]      alu_result;
   logic [2:0]       alu_flags;
   logic             grant;
   logic             grant_id;

   alu u_alu (
      .instruction (op_instr_q),
      .reg_a       (op_a_q),
      .reg_b       (op_b_q),
      .result      (alu_result),
      .flags       (alu_flags)
   );

   // rst_n gates the grant so req_ready reads 0 while reset is held, even with valid high.
   always_comb begin
      grant    = rst_n && (state_q == StIdle) && (bus.req_valid != 2'b00);
      grant_id = (bus.req_valid == 2'b11) ? ~last_grant_q : bus.req_valid[1];
   end

   assign bus.req_ready  = grant ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = cur_id_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign busy           = (state_q != StIdle);
   assign grant_cnt0     = cnt0_q;
   assign grant_cnt1     = cnt1_q;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      rsp_valid_d  = rsp_valid_q;
      op_instr_d   = op_instr_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      unique case (state_q)
         StIdle: begin
            if (grant) begin
               state_d      = StExec;
               last_grant_d = grant_id;
               cur_id_d     = grant_id;
               op_instr_d   = grant_id ? bus.req_instr1 : bus.req_instr0;
               op_a_d       = grant_id ? bus.req_a1 : bus.req_a0;
               op_b_d       = grant_id ? bus.req_b1 : bus.req_b0;
               if (grant_id) begin
                  cnt1_d = (cnt1_q == '1) ? cnt1_q : cnt1_q + 1'b1;
               end else begin
                  cnt0_d = (cnt0_q == '1) ? cnt0_q : cnt0_q + 1'b1;
               end
            end
         end
         StExec: begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_valid_d  = 1'b1;
            state_d      = StResp;
         end
         StResp: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         cur_id_q     <= 1'b0;
         rsp_valid_q  <= 1'b0;
         op_instr_q   <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         rsp_valid_q  <= rsp_valid_d;
         op_instr_q   <= op_instr_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: inputs change on the falling edge and outputs are
// sampled 1 ns later, so every check sits half a cycle away from the rising edge.
module tb_alu_share_arbiter;
   logic        clk;
   logic        rst_n;
   logic        busy, busy_s;
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt0_s, cnt1_s;
   logic [31:0] ref_instr, ref_a, ref_b, ref_result;
   logic [2:0]  ref_flags;
   int          n_vec;
   int          n_err;

   alu_share_arbiter_if bus ();
   alu_share_arbiter_if bus_s ();

   alu_share_arbiter #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .grant_cnt0 (cnt0),
      .grant_cnt1 (cnt1)
   );

   alu_share_arbiter #(.CNT_W(2)) dut_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus_s),
      .busy       (busy_s),
      .grant_cnt0 (cnt0_s),
      .grant_cnt1 (cnt1_s)
   );

   alu u_ref (
      .instruction (ref_instr),
      .reg_a       (ref_a),
      .reg_b       (ref_b),
      .result      (ref_result),
      .flags       (ref_flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      ref_instr = '0; ref_a = '0; ref_b = '0;
      bus.req_valid = 2'b11;
      bus.req_instr0 = 32'h00010022; bus.req_a0 = 32'd6; bus.req_b0 = 32'd9;
      bus.req_instr1 = 32'h20010006; bus.req_a1 = 32'd9; bus.req_b1 = 32'd0;
      bus.rsp_ready = 1'b1;
      bus_s.req_valid = 2'b00;
      bus_s.req_instr0 = 32'h00010020; bus_s.req_a0 = 32'd1; bus_s.req_b0 = 32'd1;
      bus_s.req_instr1 = '0; bus_s.req_a1 = '0; bus_s.req_b1 = '0;
      bus_s.rsp_ready = 1'b1;
      #1;
      // Reset state, with both requesters already valid
      chk("rst_ready", bus.req_ready, 2'b00);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_result", bus.rsp_result, 0);
      chk("rst_flags", bus.rsp_flags, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt0", cnt0, 0);
      chk("rst_cnt1", cnt1, 0);

      // Contention from reset: 0 first (sub), then 1 (addi)
      @(negedge clk); rst_n = 1'b1; #1;
      chk("cont_grant0", bus.req_ready, 2'b01);
      @(negedge clk); bus.req_valid = 2'b10; #1;
      chk("cont_exec_ready", bus.req_ready, 2'b00);
      chk("cont_exec_busy", busy, 1);
      chk("cont_exec_rsp_valid", bus.rsp_valid, 0);
      @(negedge clk); #1;
      chk("cont_rsp0_valid", bus.rsp_valid, 1);
      chk("cont_rsp0_id", bus.rsp_id, 0);
      chk("cont_rsp0_result", bus.rsp_result, 32'hFFFFFFFD);
      chk("cont_rsp0_flags", bus.rsp_flags, 3'b010);
      chk("cont_rsp0_no_grant", bus.req_ready, 2'b00);
      @(negedge clk); #1;
      chk("cont_grant1", bus.req_ready, 2'b10);
      @(negedge clk); bus.req_valid = 2'b00; #1;
      @(negedge clk); #1;
      chk("cont_rsp1_id", bus.rsp_id, 1);
      chk("cont_rsp1_result", bus.rsp_result, 32'h0000000F);
      chk("cont_rsp1_flags", bus.rsp_flags, 3'b000);
      @(negedge clk); #1;
      chk("cont_cnt0", cnt0, 1);
      chk("cont_cnt1", cnt1, 1);
      chk("cont_idle_busy", busy, 0);

      // Fresh start for fairness: 8 grants with both valid, AND 0 & ~0
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int g = 0; g < 8; g++) begin
         @(negedge clk);
         bus.req_valid = 2'b11;
         bus.req_instr0 = 32'h00010024; bus.req_a0 = 32'd0; bus.req_b0 = 32'hFFFFFFFF;
         bus.req_instr1 = 32'h00010024; bus.req_a1 = 32'd0; bus.req_b1 = 32'hFFFFFFFF;
         #1;
         chk("rr_grant", bus.req_ready, (g % 2 == 1) ? 2'b10 : 2'b01);
         @(negedge clk); #1;
         @(negedge clk); #1;
         chk("rr_rsp_id", bus.rsp_id, g % 2);
         chk("rr_result", bus.rsp_result, 0);
         chk("rr_flags", bus.rsp_flags, 3'b100);
      end
      @(negedge clk); bus.req_valid = 2'b00; #1;
      chk("rr_cnt0", cnt0, 4);
      chk("rr_cnt1", cnt1, 4);

      // Single add from requester 0, cross-checked against a standalone alu
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_instr0 = 32'h00010020; bus.req_a0 = 32'd6; bus.req_b0 = 32'd9;
      ref_instr = 32'h00010020; ref_a = 32'd6; ref_b = 32'd9;
      #1;
      chk("add_ready", bus.req_ready, 2'b01);
      @(negedge clk); bus.req_valid = 2'b00; #1;
      chk("add_ready_1cyc", bus.req_ready, 2'b00);
      chk("add_exec_rsp_valid", bus.rsp_valid, 0);
      @(negedge clk); #1;
      chk("add_rsp_valid", bus.rsp_valid, 1);
      chk("add_rsp_id", bus.rsp_id, 0);
      chk("add_result", bus.rsp_result, 32'h0000000F);
      chk("add_ref_result", ref_result, 32'h0000000F);
      chk("add_flags", bus.rsp_flags, 3'b000);
      chk("add_flags_vs_alu", bus.rsp_flags, ref_flags);
      @(negedge clk); #1;
      chk("add_done", bus.rsp_valid, 0);
      chk("add_cnt0", cnt0, 5);

      // Backpressure: sll by 12 with rsp_ready low for 5 cycles, requester 1 pending
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_instr0 = 32'h00010300; bus.req_a0 = 32'd0; bus.req_b0 = 32'h0F0F0F0F;
      bus.req_instr1 = 32'h00010020; bus.req_a1 = 32'd1; bus.req_b1 = 32'd2;
      #1;
      chk("bp_grant0", bus.req_ready, 2'b01);
      @(negedge clk); bus.req_valid = 2'b10; #1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk); #1;
         chk("bp_stall_valid", bus.rsp_valid, 1);
         chk("bp_stall_result", bus.rsp_result, 32'hF0F0F000);
         chk("bp_stall_flags", bus.rsp_flags, 3'b010);
         chk("bp_stall_ready", bus.req_ready, 2'b00);
      end
      @(negedge clk); bus.rsp_ready = 1'b1; #1;
      chk("bp_release_valid", bus.rsp_valid, 1);
      chk("bp_release_ready", bus.req_ready, 2'b00);
      @(negedge clk); #1;
      chk("bp_complete", bus.rsp_valid, 0);
      chk("bp_grant1", bus.req_ready, 2'b10);
      @(negedge clk); bus.req_valid = 2'b00; #1;
      @(negedge clk); #1;
      chk("bp_rsp1_id", bus.rsp_id, 1);
      chk("bp_rsp1_result", bus.rsp_result, 32'd3);

      // Reset during EXEC of an OR
      @(negedge clk);
      bus.req_valid = 2'b01;
      bus.req_instr0 = 32'h00010025; bus.req_a0 = 32'd0; bus.req_b0 = 32'hFFFFFFFF;
      #1;
      chk("mid_grant", bus.req_ready, 2'b01);
      @(negedge clk); bus.req_valid = 2'b00; #1;
      chk("mid_exec_busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
      chk("mid_rst_result", bus.rsp_result, 0);
      chk("mid_rst_flags", bus.rsp_flags, 0);
      chk("mid_rst_id", bus.rsp_id, 0);
      chk("mid_rst_cnt0", cnt0, 0);
      chk("mid_rst_cnt1", cnt1, 0);
      @(negedge clk); rst_n = 1'b1; #1;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk); #1;
         chk("mid_after_rsp_valid", bus.rsp_valid, 0);
         chk("mid_after_busy", busy, 0);
      end

      // Saturation with CNT_W=2: five back-to-back requester-0 grants
      for (int g = 0; g < 5; g++) begin
         @(negedge clk); bus_s.req_valid = 2'b01; #1;
         chk("sat_grant", bus_s.req_ready, 2'b01);
         @(negedge clk); #1;
         chk("sat_cnt0", cnt0_s, (g + 1 > 3) ? 3 : g + 1);
         chk("sat_cnt1", cnt1_s, 0);
         @(negedge clk); #1;
         chk("sat_rsp_result", bus_s.rsp_result, 32'd2);
      end
      @(negedge clk); bus_s.req_valid = 2'b00; #1;
      chk("sat_final_cnt0", cnt0_s, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single combinational `alu` (instruction, regA, regB → result, flags[2:0]) between two requesters. Requests are accepted with a valid/ready handshake, operands are registered into the ALU, and the result is captured and returned on a shared response channel tagged with the requester id. Per-requester grant counters give the datapath team visibility into ALU contention.

## Interface
- `CNT_W`, 16, width of each saturating per-requester grant counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  request valid, one bit per requester.
- `req_ready[1:0]`  out  2  request accepted this cycle, one-hot or zero.
- `req_instr0`, `req_instr1`  in  32  MIPS instruction word per requester.
- `req_a0`, `req_a1`  in  32  regA operand per requester.
- `req_b0`, `req_b1`  in  32  regB operand per requester.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester that owns the response.
- `rsp_result`  out  32  captured ALU result.
- `rsp_flags`  out  3  captured ALU flags, bit order unchanged from `alu`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_cnt0`, `grant_cnt1`  out  CNT_W  accepted-request count per requester.

## Operation
- Exactly one `alu` instance, fed only from internal operand registers `op_instr`, `op_a`, `op_b`.
- FSM: IDLE → EXEC → RESP → IDLE.
  - IDLE: if any `req_valid`, grant one requester. Assert its `req_ready`, latch its instr/a/b into the operand registers, record `cur_id`, go to EXEC. If no `req_valid`, stay.
  - EXEC: the ALU evaluates registered operands. Capture `result`/`flags` into `rsp_result`/`rsp_flags` and go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_valid && rsp_ready`, go to IDLE. Otherwise hold; outputs stay stable.
- Arbitration: `last_grant` register.
  - Only one valid: that requester wins.
  - Both valid: the requester ≠ `last_grant` wins.
  - `last_grant` updates only on a grant.
- `req_ready` is combinational from state and `req_valid`. It is never asserted outside IDLE and never asserted for a requester whose `req_valid` is low.
- Requesters hold valid and payload stable until ready. A drop of `req_valid` before grant is legal; no grant results.
- Grant counters: increment on each grant and saturate at 2^CNT_W−1 (no wrap).
- Operand registers and `rsp_result`/`rsp_flags` are not cleared on response; they hold their last value.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1 (so requester 0 wins first contention).
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_flags`=0.
  - operand registers=0, `busy`=0, `req_ready`=0, both counters=0.
- Latency: grant edge at cycle N; EXEC during N+1; `rsp_valid` high from N+2.
- Minimum spacing between grants is 3 cycles. No grant occurs in the cycle a response handshakes; the next grant is earliest one cycle later.
- `rsp_ready` high before `rsp_valid`: the response completes in its first RESP cycle.
- Stalled `rsp_ready`: requests are not accepted and `req_ready` stays 0. A requester can wait indefinitely without loss.
- Reset asserted mid-operation (EXEC or RESP): immediate return to reset values. The in-flight operation is discarded and no response is issued after reset.
- Counter at max: a further grant leaves the value unchanged; the other counter is unaffected.

## Test plan
- Single add: requester 0, instr 0x00010020, a=6, b=9.
  - `req_ready[0]` high for 1 cycle.
  - 2 cycles later: `rsp_valid`=1, `rsp_id`=0, `rsp_result`=0x0000000F.
  - `rsp_flags` equal to a standalone `alu` given the same inputs.
- Contention: both requesters valid from reset.
  - Requester 0: sub 0x00010022, a=6, b=9. Requester 1: addi 0x20010006, a=9.
  - Grants go 0 then 1.
  - Responses: id0 result 0xFFFFFFFD, then id1 result 0x0000000F.
  - Counters then read 1/1.
- Round-robin fairness: both requesters held valid for 8 grants (and 0x00010024, a=0, b=0xFFFFFFFF).
  - Grants strictly alternate 0,1,0,1…
  - Each `rsp_result`=0; each counter ends at 4.
- Backpressure: sll 0x00010300, b=0x0F0F0F0F, `rsp_ready` low for 5 cycles.
  - `rsp_result`=0xF0F0F000, stable throughout the stall.
  - `req_ready`=0 throughout despite a pending requester 1.
  - Completion 1 cycle after `rsp_ready` rises.
- Reset mid-op: assert `rst_n`=0 during EXEC of or 0x00010025 (a=0, b=0xFFFFFFFF).
  - All outputs at reset values asynchronously.
  - After release, no response appears until a new grant.
- Counter saturation (CNT_W=2): 5 consecutive requester-0 grants.
  - `grant_cnt0` reads 1,2,3,3,3.
  - `grant_cnt1` stays 0.
